// File: rtl/stream_fork_dynamic_buffered.sv
// Dynamic stream fork: each input beat is copied into the per-output FIFOs picked by sel_i.
// Optional beat-drop counter enabled by defining STREAM_FORK_DYN_DROP_CNT_EN.
module stream_fork_dynamic_buffered #(
  parameter int unsigned N_OUP      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [N_OUP-1:0]            sel_i,
  input  logic                        sel_valid_i,
  output logic                        sel_ready_o,
  output logic [N_OUP*DATA_WIDTH-1:0] data_o,
  output logic [N_OUP-1:0]            valid_o,
  input  logic [N_OUP-1:0]            ready_i,
  output logic [15:0]                 drop_cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [N_OUP-1:0] full;
  logic [N_OUP-1:0] push;
  logic [N_OUP-1:0] pop;
  logic             blocked;
  logic             xfer;

  // Explicit compare-and-clear so non-power-of-2 depths wrap correctly.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Only full FIFOs that are actually selected hold off the input; a pop in
  // the same cycle does not help, which keeps ready_i out of the ready_o cone.
  always_comb begin
    blocked = 1'b0;
    for (int unsigned i = 0; i < N_OUP; i++) begin
      if (sel_i[i] && full[i]) blocked = 1'b1;
    end
  end

  assign ready_o     = sel_valid_i & ~blocked;
  assign sel_ready_o = ready_o;
  assign xfer        = valid_i & ready_o;

  for (genvar g = 0; g < N_OUP; g++) begin : g_out
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    cnt_t                  count;

    assign full[g]    = (count == cnt_t'(DEPTH));
    assign valid_o[g] = (count != '0);
    assign push[g]    = xfer & sel_i[g];
    assign pop[g]     = valid_o[g] & ready_i[g];
    assign data_o[g*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else begin
        if (push[g]) begin
          mem[wr_ptr] <= data_i;
          wr_ptr      <= ptr_next(wr_ptr);
        end
        if (pop[g]) rd_ptr <= ptr_next(rd_ptr);
        if (push[g] && !pop[g]) count <= count + cnt_t'(1);
        else if (!push[g] && pop[g]) count <= count - cnt_t'(1);
      end
    end
  end

`ifdef STREAM_FORK_DYN_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else if (xfer && (sel_i == '0) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_fork_dynamic_buffered.sv
// Scoreboard bench for stream_fork_dynamic_buffered: instance a (DEPTH=2) and instance b (DEPTH=3).
module tb_stream_fork_dynamic_buffered;
  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]   data_a, data_b;
  logic            valid_a, valid_b, sel_valid_a, sel_valid_b;
  logic            ready_out_a, ready_out_b, sel_ready_a, sel_ready_b;
  logic [N-1:0]    sel_a, sel_b, ready_in_a, ready_in_b, valid_out_a, valid_out_b;
  logic [N*DW-1:0] data_out_a, data_out_b;
  logic [15:0]     drop_a, drop_b;

  stream_fork_dynamic_buffered #(.N_OUP(N), .DATA_WIDTH(DW), .DEPTH(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data_a), .valid_i(valid_a), .ready_o(ready_out_a),
    .sel_i(sel_a), .sel_valid_i(sel_valid_a), .sel_ready_o(sel_ready_a),
    .data_o(data_out_a), .valid_o(valid_out_a), .ready_i(ready_in_a), .drop_cnt_o(drop_a)
  );

  stream_fork_dynamic_buffered #(.N_OUP(N), .DATA_WIDTH(DW), .DEPTH(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data_b), .valid_i(valid_b), .ready_o(ready_out_b),
    .sel_i(sel_b), .sel_valid_i(sel_valid_b), .sel_ready_o(sel_ready_b),
    .data_o(data_out_b), .valid_o(valid_out_b), .ready_i(ready_in_b), .drop_cnt_o(drop_b)
  );

  typedef logic [DW-1:0] beat_q_t[$];
  beat_q_t     qa[N];
  beat_q_t     qb[N];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] drop_exp = '0;
  bit          xfer_a, xfer_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic score_a();
    logic ready_exp;
    ready_exp = sel_valid_a;
    for (int i = 0; i < N; i++) if (sel_a[i] && qa[i].size() >= 2) ready_exp = 1'b0;
    check("ready_a", 32'(ready_out_a), 32'(ready_exp));
    check("sel_ready_a", 32'(sel_ready_a), 32'(ready_exp));
    for (int i = 0; i < N; i++) begin
      check("valid_a", 32'(valid_out_a[i]), 32'(qa[i].size() != 0));
      if (qa[i].size() != 0) check("data_a", 32'(data_out_a[i*DW +: DW]), 32'(qa[i][0]));
    end
    check("drop_a", 32'(drop_a), 32'(drop_exp));
    xfer_a = valid_a && ready_exp;
    for (int i = 0; i < N; i++)
      if (valid_out_a[i] && ready_in_a[i] && qa[i].size() != 0) void'(qa[i].pop_front());
    if (xfer_a) begin
      for (int i = 0; i < N; i++) if (sel_a[i]) qa[i].push_back(data_a);
`ifdef STREAM_FORK_DYN_DROP_CNT_EN
      if (sel_a == '0 && drop_exp != 16'hFFFF) drop_exp++;
`endif
    end
  endtask

  task automatic score_b();
    logic ready_exp;
    ready_exp = sel_valid_b;
    for (int i = 0; i < N; i++) if (sel_b[i] && qb[i].size() >= 3) ready_exp = 1'b0;
    check("ready_b", 32'(ready_out_b), 32'(ready_exp));
    check("sel_ready_b", 32'(sel_ready_b), 32'(ready_exp));
    for (int i = 0; i < N; i++) begin
      check("valid_b", 32'(valid_out_b[i]), 32'(qb[i].size() != 0));
      if (qb[i].size() != 0) check("data_b", 32'(data_out_b[i*DW +: DW]), 32'(qb[i][0]));
    end
    xfer_b = valid_b && ready_exp;
    for (int i = 0; i < N; i++)
      if (valid_out_b[i] && ready_in_b[i] && qb[i].size() != 0) void'(qb[i].pop_front());
    if (xfer_b) for (int i = 0; i < N; i++) if (sel_b[i]) qb[i].push_back(data_b);
  endtask

  task automatic tick();
    @(negedge clk);
    score_a();
    score_b();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer_a(input string tag);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (xfer_a) break;
    end
    if (!xfer_a) check(tag, 32'(0), 32'(1));
  endtask

  task automatic send_a(input logic [DW-1:0] d, input logic [N-1:0] s);
    data_a = d; sel_a = s; valid_a = 1'b1; sel_valid_a = 1'b1;
    wait_xfer_a("send_timeout");
    valid_a = 1'b0; sel_valid_a = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    data_a = '0; sel_a = '0; valid_a = 1'b0; sel_valid_a = 1'b0; ready_in_a = '1;
    data_b = '0; sel_b = '0; valid_b = 1'b0; sel_valid_b = 1'b0; ready_in_b = '1;
    #2 rst = 1'b1;
    #3;
    check("reset_valid", 32'(valid_out_a), 32'(0));
    check("reset_data", 32'(data_out_a), 32'(0));
    check("reset_drop", 32'(drop_a), 32'(0));
    check("reset_valid_b", 32'(valid_out_b), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Multicast to outputs 0 and 2
    send_a(8'hA5, 3'b101);
    check("t1_valid", 32'(valid_out_a), 32'(3'b101));
    check("t1_data0", 32'(data_out_a[0 +: DW]), 32'(8'hA5));
    check("t1_data2", 32'(data_out_a[2*DW +: DW]), 32'(8'hA5));
    tick();
    check("t1_gone", 32'(valid_out_a), 32'(0));

    // Output 1 stalled until its FIFO fills
    ready_in_a = 3'b101;
    send_a(8'h01, 3'b010);
    send_a(8'h02, 3'b010);
    data_a = 8'h03; sel_a = 3'b010; valid_a = 1'b1; sel_valid_a = 1'b1;
    idle(3);
    check("t2_stall", 32'(ready_out_a), 32'(0));
    ready_in_a = 3'b111;
    wait_xfer_a("t2_resume");
    valid_a = 1'b0; sel_valid_a = 1'b0;
    idle(4);
    check("t2_drained", 32'(valid_out_a), 32'(0));

    // Full output 0 blocks only beats that select it
    ready_in_a = 3'b110;
    send_a(8'h11, 3'b001);
    send_a(8'h12, 3'b001);
    send_a(8'h13, 3'b110);
    data_a = 8'h14; sel_a = 3'b011; valid_a = 1'b1; sel_valid_a = 1'b1;
    idle(3);
    check("t3_stall", 32'(ready_out_a), 32'(0));
    ready_in_a = 3'b111;
    wait_xfer_a("t3_resume");
    valid_a = 1'b0; sel_valid_a = 1'b0;
    idle(4);

    // DEPTH=3 instance: continuous push+pop on output 2 walks pointers through wrap
    data_b = 8'h40; sel_b = 3'b100; valid_b = 1'b1; sel_valid_b = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (xfer_b) data_b = data_b + 8'd1;
      if (k > 0) check("t4_valid", 32'(valid_out_b[2]), 32'(1));
    end
    valid_b = 1'b0; sel_valid_b = 1'b0;
    idle(3);
    check("t4_drained", 32'(valid_out_b), 32'(0));

    // Empty select drops beats
    for (int k = 0; k < 5; k++) begin
      send_a(8'(8'h60 + k), 3'b000);
      check("t5_valid", 32'(valid_out_a), 32'(0));
    end
`ifdef STREAM_FORK_DYN_DROP_CNT_EN
    check("t5_drop5", 32'(drop_a), 32'(5));
    while (drop_exp < 16'hFFFE) send_a(8'h77, 3'b000);
    check("t5_preload", 32'(drop_a), 32'(16'hFFFE));
    for (int k = 0; k < 3; k++) send_a(8'h78, 3'b000);
    check("t5_sat", 32'(drop_a), 32'(16'hFFFF));
`else
    check("t5_drop0", 32'(drop_a), 32'(0));
`endif

    // Async reset with two beats buffered per output
    ready_in_a = 3'b000;
    send_a(8'h21, 3'b111);
    send_a(8'h22, 3'b111);
    data_a = 8'h23; sel_a = 3'b111; valid_a = 1'b1; sel_valid_a = 1'b1;
    idle(1);
    check("t6_full", 32'(valid_out_a), 32'(3'b111));
    #3 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(valid_out_a), 32'(0));
    check("t6_rst_data", 32'(data_out_a), 32'(0));
    for (int i = 0; i < N; i++) qa[i].delete();
    drop_exp = '0;
    valid_a = 1'b0; sel_valid_a = 1'b0; ready_in_a = 3'b111;
    idle(2);
    rst = 1'b0;
    idle(1);
    send_a(8'h5A, 3'b111);
    check("t6_new_valid", 32'(valid_out_a), 32'(3'b111));
    check("t6_new_data", 32'(data_out_a), 32'(24'h5A5A5A));
    tick();
    check("t6_new_gone", 32'(valid_out_a), 32'(0));
    check("drop_b", 32'(drop_b), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_fork_dynamic_buffered.md
Name: stream_fork_dynamic_buffered

Overview:
- Data-carrying dynamic stream fork. Each input beat goes to the subset of N_OUP outputs chosen by a one-hot-or-multi-hot select handshake.
- Every output has its own DEPTH-entry FIFO, so a slow consumer stalls the input only once its own FIFO is full, not on every beat.
- Sits between the AXI request splitter and per-bank memory ports in the axi_to_mem path. It replaces the unbuffered dynamic fork where consumers run decoupled.

Parameters:
- N_OUP, 4, number of outputs (>=1).
- DATA_WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, entries per output FIFO (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- data_i  in  DATA_WIDTH  input payload.
- valid_i  in  1  input valid.
- ready_o  out  1  input ready.
- sel_i  in  N_OUP  output select mask, bit i routes the beat to output i.
- sel_valid_i  in  1  select valid.
- sel_ready_o  out  1  select ready; always equal to ready_o.
- data_o  out  N_OUP*DATA_WIDTH  output payloads, output i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_o  out  N_OUP  per-output valid.
- ready_i  in  N_OUP  per-output ready.
- drop_cnt_o  out  16  count of beats accepted with an empty select (see Optional Feature).

Behaviour:
- Reset (rst_i high, async): all FIFO counts, read and write pointers 0; valid_o=0; data_o=0; drop_cnt_o=0. Reset mid-operation discards all buffered beats immediately; no output handshake may complete while rst_i is high.
- Per output i: FIFO with count register of width $clog2(DEPTH+1). full_i = (count_i==DEPTH). valid_o[i] = (count_i!=0). data_o slice = FIFO head.
- ready_o = sel_ready_o = sel_valid_i AND (for all i: !sel_i[i] OR !full_i).
  - ready_o never depends on valid_i or on ready_i (no combinational ready_i->ready_o path).
  - A full FIFO blocks the input even if it is popped in the same cycle.
- Transfer: fires when valid_i & sel_valid_i & ready_o. Both handshakes complete in the same cycle; one select per beat.
- On a transfer, data_i is written into every FIFO i with sel_i[i]=1.
- Latency: a beat written in cycle N is visible on valid_o/data_o in cycle N+1 at the earliest. There is no combinational data_i->data_o path.
- Pop: output handshake valid_o[i] & ready_i[i] advances read pointer i.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH, including non-power-of-2 DEPTH (explicit compare-and-clear).
- Output ordering: each output sees its selected beats in input order. There is no cross-output ordering.
- Empty select (sel_i==0): when valid_i & sel_valid_i, ready_o=1 and the beat is consumed and dropped.
- Output stability: while valid_o[i] & !ready_i[i], data_o slice i and valid_o[i] hold.
- Protocol rules enforced by the bench, not by the RTL:
  - valid_i, data_i, sel_i and sel_valid_i stay stable until the handshake completes.
  - valid_o never deasserts without a handshake.

Optional Feature:
- Macro STREAM_FORK_DYN_DROP_CNT_EN.
- Defined: drop_cnt_o is a 16-bit register. It increments by 1 on each transfer with sel_i==0 and saturates at 16'hFFFF. It resets to 0.
- Not defined: drop_cnt_o is tied to 16'h0000 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- N_OUP=3, DEPTH=2, DATA_WIDTH=8, all ready_i=1. Send beat 8'hA5 with sel 3'b101 -> next cycle valid_o=3'b101; slices 0 and 2 = 8'hA5; valid_o[1]=0; the beat is gone one cycle later.
- ready_i[1]=0. Send 8'h01, 8'h02, 8'h03 with sel 3'b010 back-to-back -> first two accepted, ready_o=0 on the third. Raise ready_i[1] -> output 1 delivers 01, 02, then 03; ready_o returns high in the cycle after the first pop.
- ready_i=3'b110 (output 0 stalled). Send sel 3'b001 until full, then a beat with sel 3'b110 -> the 3'b110 beat is accepted while output 0 is full; the next sel 3'b011 beat stalls.
- Simultaneous push/pop at count=1 on output 2 over 10 cycles -> count stays 1, data order preserved, pointers wrap correctly with DEPTH=3.
- Send 5 beats with sel_i=0 -> each accepted in one cycle, valid_o stays 0; drop_cnt_o=5 with the macro, 0 without. With the macro, preload 16'hFFFE and send 3 more -> holds 16'hFFFF.
- Assert rst_i asynchronously mid-burst with 2 beats buffered per output -> valid_o=0 immediately; after release, the first new beat appears with 1-cycle latency and no stale data.
